fp_square_seq: RTL

//  Sequential IEEE-754 single-precision squarer: solution = operand * operand.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_classify.sv | 26 ++
 rtl/fp_square_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision FP datapath blocks:
// sequencer states, IEEE-754 field geometry and canonical special results.
package fp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int SIGN_BIT = 31;
   localparam int EXP_W_SP = 8;
   localparam int FRAC_W_SP = 23;
   localparam int BIAS = 127;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;
   localparam logic [31:0] PZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
// The sign bit plays no part in classification.
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0] value,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_nan,
   output logic        is_denorm
);

   logic [EXP_W_SP-1:0]  ex;
   logic [FRAC_W_SP-1:0] fr;
   logic                 unused_sign;

   assign ex          = value[SIGN_BIT-1 -: EXP_W_SP];
   assign fr          = value[FRAC_W_SP-1:0];
   assign unused_sign = value[SIGN_BIT];

   assign is_zero   = (ex == '0) && (fr == '0);
   assign is_denorm = (ex == '0) && (fr != '0);
   assign is_inf    = (ex == '1) && (fr == '0);
   assign is_nan    = (ex == '1) && (fr != '0);

endmodule

// File: rtl/fp_square_seq.sv
// Sequential IEEE-754 single squarer: one shift-add partial product per clock,
// then a single normalise/pack step. Rounds toward zero, flushes to +0.
module fp_square_seq
   import fp_pkg::*;
#(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8,
   parameter int BIAS   = 127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] solution,
   output logic        busy
);

   localparam int ACC_W  = 2 * MANT_W;
   localparam int CNT_W  = $clog2(MANT_W);
   localparam int FRAC_W = MANT_W - 1;
   localparam int E_W    = EXP_W + 2;

   localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
   localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
   localparam logic signed [E_W-1:0] E_INF  = E_W'((1 << EXP_W) - 1);
   localparam logic signed [E_W-1:0] E_ZERO = '0;

   state_t             state, state_nxt;
   logic [EXP_W-1:0]   exp_q;
   logic [MANT_W-1:0]  mant;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc;
   logic               is_zero, is_inf, is_nan, is_denorm;
   logic               special;
   logic [31:0]        special_res;
   logic               accept;

   // Product is in [1,4): bit ACC_W-1 set means the 2.x range, so bump the exponent.
   function automatic logic [31:0] norm_pack(input logic [ACC_W-1:0] a,
                                             input logic [EXP_W-1:0] ex);
      logic signed [E_W-1:0] e;
      logic [FRAC_W-1:0]     frac;
      e = $signed({1'b0, ex, 1'b0}) - BIAS_S;
      if (a[ACC_W-1]) begin
         frac = a[ACC_W-2 -: FRAC_W];
         e    = e + E_ONE;
      end else begin
         frac = a[ACC_W-3 -: FRAC_W];
      end
      if (e >= E_INF)
         norm_pack = PINF;
      else if (e <= E_ZERO)
         norm_pack = PZERO;
      else
         norm_pack = {1'b0, e[EXP_W-1:0], frac};
   endfunction

   fp_classify u_classify (
      .value     (operand),
      .is_zero   (is_zero),
      .is_inf    (is_inf),
      .is_nan    (is_nan),
      .is_denorm (is_denorm)
   );

   assign special     = is_zero | is_denorm | is_inf | is_nan;
   assign special_res = is_nan ? QNAN : (is_inf ? PINF : PZERO);

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = special ? DONE : MULT;
         MULT: if (cnt == '0) state_nxt = NORM;
         NORM: state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Multiplier scans its own bits from MSB down; one conditional add per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q    <= '0;
         mant     <= '0;
         cnt      <= '0;
         acc      <= '0;
         solution <= PZERO;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  exp_q <= operand[FRAC_W +: EXP_W];
                  mant  <= {1'b1, operand[FRAC_W-1:0]};
                  acc   <= '0;
                  cnt   <= CNT_W'(MANT_W - 1);
                  if (special)
                     solution <= special_res;
               end
            end
            MULT: begin
               if (mant[cnt])
                  acc <= acc + (ACC_W'(mant) << cnt);
               cnt <= cnt - 1'b1;
            end
            NORM: solution <= norm_pack(acc, exp_q);
            default: ;
         endcase
      end
   end

endmodule
